divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 160 ++++++++++++++++
 tb/tb_divider_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle DIV/DIVU/REM/REMU unit for the register-file writeback path.
// A restoring shift-subtract core produces one quotient bit per clock. Divide-by-zero
// and signed-overflow cases skip the core and finish straight from IDLE.
module divider_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] Read_Data_1_i,
  input  logic [N-1:0] Read_Data_2_i,
  input  logic [4:0]   rd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  output logic         Reg_Write_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [5:0]   LAST_ITER = 6'(N - 1);
  localparam logic [N-1:0] MIN_NEG   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES  = '1;

  state_t       state;
  logic [5:0]   count;
  logic [N-1:0] quo_q;
  logic [N-1:0] rem_q;
  logic [N-1:0] divisor_q;
  logic         is_rem_q;
  logic         neg_quo_q;
  logic         neg_rem_q;
  logic [4:0]   rd_q;

  logic         op_signed;
  logic         op_rem;
  logic         div_zero;
  logic         overflow;
  logic [N-1:0] dividend_mag;
  logic [N-1:0] divisor_mag;
  logic [N-1:0] special_result;

  // Decode a new request: operand magnitudes, sign fixups and the early-exit result.
  always_comb begin
    op_signed      = ~op_i[0];
    op_rem         = op_i[1];
    div_zero       = (Read_Data_2_i == '0);
    overflow       = op_signed && (Read_Data_1_i == MIN_NEG) && (Read_Data_2_i == ALL_ONES);
    dividend_mag   = (op_signed && Read_Data_1_i[N-1]) ? -Read_Data_1_i : Read_Data_1_i;
    divisor_mag    = (op_signed && Read_Data_2_i[N-1]) ? -Read_Data_2_i : Read_Data_2_i;
    special_result = '0;
    if (div_zero) begin
      special_result = op_rem ? Read_Data_1_i : ALL_ONES;
    end else if (overflow) begin
      special_result = op_rem ? '0 : MIN_NEG;
    end
  end

  logic [N:0]   rem_shift;
  logic [N:0]   trial;
  logic         fits;
  logic [N-1:0] rem_next;
  logic [N-1:0] quo_next;
  logic [N-1:0] final_result;

  // One restoring step: the quotient register shifts its dividend bits out into the
  // partial remainder while the new quotient bits shift in from the bottom.
  always_comb begin
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    fits      = ~trial[N];
    rem_next  = fits ? trial[N-1:0] : rem_shift[N-1:0];
    quo_next  = {quo_q[N-2:0], fits};
    if (is_rem_q) begin
      final_result = neg_rem_q ? -rem_next : rem_next;
    end else begin
      final_result = neg_quo_q ? -quo_next : quo_next;
    end
  end

  // Control FSM and datapath registers; every output is driven from a flop here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      quo_q            <= '0;
      rem_q            <= '0;
      divisor_q        <= '0;
      is_rem_q         <= 1'b0;
      neg_quo_q        <= 1'b0;
      neg_rem_q        <= 1'b0;
      rd_q             <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      Reg_Write_o      <= 1'b0;
      Write_Data_o     <= '0;
      Write_Register_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o      <= 1'b0;
          Reg_Write_o <= 1'b0;
          if (start_i) begin
            is_rem_q  <= op_rem;
            neg_quo_q <= op_signed && (Read_Data_1_i[N-1] ^ Read_Data_2_i[N-1]);
            neg_rem_q <= op_signed && Read_Data_1_i[N-1];
            rd_q      <= rd_i;
            quo_q     <= dividend_mag;
            rem_q     <= '0;
            divisor_q <= divisor_mag;
            count     <= '0;
            busy_o    <= 1'b1;
            if (div_zero || overflow) begin
              state            <= DONE;
              done_o           <= 1'b1;
              Write_Data_o     <= special_result;
              Write_Register_o <= rd_i;
              Reg_Write_o      <= (rd_i != 5'd0);
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          count <= count + 6'd1;
          if (count == LAST_ITER) begin
            state            <= DONE;
            count            <= '0;
            done_o           <= 1'b1;
            Write_Data_o     <= final_result;
            Write_Register_o <= rd_q;
            Reg_Write_o      <= (rd_q != 5'd0);
          end
        end
        DONE: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
          Reg_Write_o <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
          Reg_Write_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: randomized and directed checks of divider_unit against an
// arithmetic reference model (native integer division plus the documented corner rules).
module tb_divider_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        reg_write;

  int checks = 0;
  int errors = 0;

  divider_unit #(.N(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .op_i             (op_i),
    .Read_Data_1_i    (read_data_1),
    .Read_Data_2_i    (read_data_2),
    .rd_i             (rd_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .Write_Register_o (write_register),
    .Write_Data_o     (write_data),
    .Reg_Write_o      (reg_write)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic and the corner-case rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Edges after the start edge until done_o shows: 0 for early exits, 32 otherwise.
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done_o, returning what was observed.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, output int edges, output logic [31:0] data,
                               output logic [4:0] wreg, output logic rw, output logic timed_out);
    op_i        = op;
    read_data_1 = a;
    read_data_2 = b;
    rd_i        = rd;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    edges   = 0;
    while (done_o !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    timed_out = (done_o !== 1'b1);
    data      = write_data;
    wreg      = write_register;
    rw        = reg_write;
  endtask

  // Reset clears all outputs, wins over start_i, and a start right after reset is taken.
  task automatic test_reset();
    int edges;
    logic [31:0] data;
    logic [4:0] wreg;
    logic rw, to;
    reset = 1'b1;
    start_i = 1'b1;
    op_i = OP_DIVU;
    read_data_1 = 32'd50;
    read_data_2 = 32'd0;
    rd_i = 5'd3;
    tick();
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite: got %b expected 0", reg_write); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", write_data); end
    checks++; if (write_register !== 5'd0) begin errors++; $display("[TB] FAIL reset_wreg: got %0d expected 0", write_register); end
    reset = 1'b0;
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd7, edges, data, wreg, rw, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL post_reset_start: got no done expected done"); end
    checks++; if (edges !== 32) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 32", edges); end
    checks++; if (data !== 32'd3) begin errors++; $display("[TB] FAIL post_reset_data: got %h expected 00000003", data); end
    checks++; if (wreg !== 5'd7 || rw !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_wb: got rd=%0d we=%b expected rd=7 we=1", wreg, rw); end
    tick();
  endtask

  // Hand-picked operations including divide-by-zero, overflow and sign handling.
  task automatic test_directed();
    logic [1:0]  op_tab[10]  = '{OP_DIVU, OP_DIV, OP_REM, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIVU};
    logic [31:0] a_tab[10]   = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b_tab[10]   = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    logic [4:0]  rd_tab[10]  = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd8, 5'd9, 5'd10, 5'd31};
    logic [31:0] exp_tab[10] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF};
    int          lat_tab[10] = '{32, 32, 32, 32, 0, 0, 0, 0, 32, 32};
    int edges;
    logic [31:0] data;
    logic [4:0] wreg;
    logic rw, to;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(op_tab[i], a_tab[i], b_tab[i], rd_tab[i], edges, data, wreg, rw, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL dir%0d_timeout: got no done expected done", i); end
      checks++; if (data !== exp_tab[i]) begin errors++; $display("[TB] FAIL dir%0d_data: got %h expected %h", i, data, exp_tab[i]); end
      checks++; if (edges !== lat_tab[i]) begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, edges, lat_tab[i]); end
      checks++; if (wreg !== rd_tab[i] || rw !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_wb: got rd=%0d we=%b expected rd=%0d we=1", i, wreg, rw, rd_tab[i]); end
      tick();
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_pulse: got done=%b busy=%b we=%b expected 0 0 0", i, done_o, busy_o, reg_write); end
      checks++; if (write_data !== exp_tab[i]) begin errors++; $display("[TB] FAIL dir%0d_hold: got %h expected %h", i, write_data, exp_tab[i]); end
    end
  endtask

  // Random operations, with a bias towards zero divisors, overflow and small divisors.
  task automatic test_random();
    int edges;
    int exp_lat;
    int sel;
    logic [31:0] data, a, b, exp;
    logic [4:0] wreg, rd;
    logic [1:0] op;
    logic rw, to;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel < 5) begin
        b = 32'($urandom_range(1, 50));
        if (sel == 4) b = -b;
      end else begin
        b = $urandom;
      end
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      applyStimulus(op, a, b, rd, edges, data, wreg, rw, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL rnd%0d_timeout: got no done expected done", i); end
      checks++; if (data !== exp) begin errors++; $display("[TB] FAIL rnd%0d_data: op=%0d a=%h b=%h got %h expected %h", i, op, a, b, data, exp); end
      checks++; if (edges !== exp_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, edges, exp_lat); end
      checks++; if (wreg !== rd || rw !== (rd != 5'd0)) begin errors++; $display("[TB] FAIL rnd%0d_wb: got rd=%0d we=%b expected rd=%0d we=%b", i, wreg, rw, rd, rd != 5'd0); end
      tick();
      checks++; if (done_o !== 1'b0 || write_data !== exp) begin errors++; $display("[TB] FAIL rnd%0d_hold: got done=%b data=%h expected done=0 data=%h", i, done_o, write_data, exp); end
    end
  endtask

  // A second start during BUSY is dropped: one pulse, original result, busy over E0..E33.
  task automatic test_ignore_start();
    int done_count;
    logic [31:0] seen;
    logic exp_busy;
    done_count = 0;
    seen = 32'h0;
    op_i = OP_DIVU;
    read_data_1 = 32'd100;
    read_data_2 = 32'd7;
    rd_i = 5'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k <= 33) begin
        exp_busy = (k < 33);
        checks++; if (busy_o !== exp_busy) begin errors++; $display("[TB] FAIL ign_busy_E%0d: got %b expected %b", k, busy_o, exp_busy); end
      end
      if (done_o === 1'b1) begin
        done_count++;
        seen = write_data;
        checks++; if (k != 32) begin errors++; $display("[TB] FAIL ign_done_edge: got E%0d expected E32", k); end
      end
      if (k == 9) begin
        op_i = OP_DIVU;
        read_data_1 = 32'd9;
        read_data_2 = 32'd3;
        rd_i = 5'd12;
        start_i = 1'b1;
      end
      if (k == 10) start_i = 1'b0;
      tick();
    end
    checks++; if (done_count !== 1) begin errors++; $display("[TB] FAIL ign_pulses: got %0d expected 1", done_count); end
    checks++; if (seen !== 32'd14) begin errors++; $display("[TB] FAIL ign_data: got %h expected 0000000e", seen); end
    checks++; if (write_register !== 5'd5) begin errors++; $display("[TB] FAIL ign_wreg: got %0d expected 5", write_register); end
  endtask

  // Reset mid-operation aborts it silently; a following rd=0 request completes without a write.
  task automatic test_reset_abort();
    int edges;
    int late_done;
    logic [31:0] data;
    logic [4:0] wreg;
    logic rw, to;
    late_done = 0;
    op_i = OP_DIVU;
    read_data_1 = 32'd100;
    read_data_2 = 32'd7;
    rd_i = 5'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: got busy=%b done=%b we=%b expected 0 0 0", busy_o, done_o, reg_write); end
    checks++; if (write_data !== 32'h0 || write_register !== 5'd0) begin errors++; $display("[TB] FAIL abort_outputs: got data=%h rd=%0d expected 00000000 0", write_data, write_register); end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_o !== 1'b0 || busy_o !== 1'b0) late_done++;
      tick();
    end
    checks++; if (late_done !== 0) begin errors++; $display("[TB] FAIL abort_silent: got %0d active cycles expected 0", late_done); end
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd0, edges, data, wreg, rw, to);
    checks++; if (to || edges !== 32) begin errors++; $display("[TB] FAIL abort_next_done: got timeout=%b edges=%0d expected 0 32", to, edges); end
    checks++; if (data !== 32'd3) begin errors++; $display("[TB] FAIL abort_next_data: got %h expected 00000003", data); end
    checks++; if (rw !== 1'b0 || wreg !== 5'd0) begin errors++; $display("[TB] FAIL abort_next_wb: got we=%b rd=%0d expected 0 0", rw, wreg); end
    tick();
  endtask

  // Run all scenarios in order, then report.
  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    op_i = 2'b00;
    read_data_1 = 32'h0;
    read_data_2 = 32'h0;
    rd_i = 5'd0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
